avalon_st_rx_mailbox: RTL and testbench
=======================================

# avalon_st_rx_mailbox

Avalon-ST sink that buffers incoming packets in an internal FIFO and exposes them to a processor through an Avalon-MM slave register window. It terminates a stream produced by an upstream Avalon-ST source and is read by an Avalon-MM master, typically a PS-side bridge. It tracks packet framing, counts complete packets, and flags framing errors.

## Interface
- DATA_WIDTH, 32: ST data width and MM data width; must be 32.
- ADDRESS_WIDTH, 8: MM word address width.
- ERROR_WIDTH, 1: ST error width.
- DEPTH, 256: FIFO depth in words; power of two, 4 to 65536.
- Clk_CI  in  1  single clock; all logic is rising-edge.
- Rst_RI  in  1  synchronous, active-high reset.
- StReady_SO  out  1  sink ready; readyLatency 0.
- StValid_SI  in  1  source word valid.
- StSop_SI  in  1  start of packet.
- StEop_SI  in  1  end of packet.
- StEmpty_SI  in  2  empty byte count on the EOP word.
- StError_SI  in  ERROR_WIDTH  error flags; OR-reduced to 1 stored bit.
- StData_DI  in  DATA_WIDTH  stream data.
- MmAddress_DI  in  ADDRESS_WIDTH  word address.
- MmRead_SI  in  1  read strobe.
- MmWrite_SI  in  1  write strobe.
- MmWriteData_DI  in  DATA_WIDTH  write data.
- MmReadData_DO  out  DATA_WIDTH  read data.
- MmWaitRequest_SO  out  1  wait request.

## Operation
- A word is accepted on a cycle where StValid_SI=1 and StReady_SO=1. StReady_SO = !Rst_RI && level<DEPTH.
- The FIFO entry is {data, eop, empty[1:0], err}. The sink FSM has two states, IDLE and IN_PKT.
  - IDLE with SOP: store the word. If EOP is also set, stay in IDLE; otherwise go to IN_PKT.
  - IDLE without SOP: drop the word and set sticky ORPHAN.
  - IN_PKT with SOP: store the word, set sticky SOPERR, stay in IN_PKT.
  - IN_PKT with EOP: store the word and go to IDLE.
- Packet count PKTCNT (16 bit) increments when an EOP word is stored and decrements when an EOP word is popped. When both happen in one cycle it is unchanged.
- MM register map (word addresses). Unmapped addresses read 0 and ignore writes.
  - 0x0 STATUS (read-only): [0] PKTCNT!=0, [1] full, [2] ORPHAN, [3] SOPERR, [31:16] PKTCNT.
  - 0x1 DATA (read-only): returns the head data word and pops it. When the FIFO is empty it returns 0 and does not pop. Popping is allowed for a partial packet.
  - 0x2 META (read-only, no pop): [0] head eop, [2:1] head empty, [3] head err, [31] FIFO non-empty. Reads 0 when the FIFO is empty.
  - 0x3 LEVEL (read-only): [16:0] words currently stored.
  - 0x4 CONTROL (write-only, reads 0):
    - bit0 FLUSH: level, pointers and PKTCNT go to 0; the FSM goes to IDLE.
    - bit1 CLRERR: clears ORPHAN and SOPERR.
- A word accepted in the same cycle as a FLUSH write is discarded.
- An ORPHAN or SOPERR event coincident with CLRERR leaves the bit set.
- Reset clears the FIFO, PKTCNT, the stickies and the FSM (IDLE). A packet in flight at reset is lost. Its trailing words after reset are ORPHAN drops.

## Timing
- Reset outputs:
  - StReady_SO=0
  - MmWaitRequest_SO=1
  - MmReadData_DO=0
- Read transaction:
  - Cycle N: MmRead_SI=1 and MmWaitRequest_SO=1; the register is sampled at the end of cycle N.
  - Cycle N+1: MmWaitRequest_SO=0 and MmReadData_DO is valid; the master holds MmRead_SI. The DATA pop takes effect at the end of N+1.
  - Back-to-back reads therefore take 2 cycles each.
- MmWaitRequest_SO = Rst_RI || (MmRead_SI && !ack_q), where ack_q is 1 only in the cycle after a first read cycle.
- Writes complete with zero wait states; MmWaitRequest_SO=0 when MmWrite_SI=1. The effect is visible from the next cycle.
- MmReadData_DO holds its last value when not acknowledging a read.
- A pushed word is visible in LEVEL, META and STATUS on the cycle after acceptance. StReady_SO reflects a pop on the cycle after the pop.
- Full case: with level=DEPTH, StReady_SO=0. A pop at the end of cycle N gives StReady_SO=1 in N+1. No push into a full FIFO ever occurs.
- Simultaneous push and pop leaves the level unchanged.
- Read and write strobes are never both asserted. If they are, the write is ignored.

## Test plan
- Reset then packet: send a 3-word packet 0xA1,0xA2,0xA3 (SOP on the first word, EOP with empty=2 on the last).
  - STATUS=0x0001_0001, LEVEL=3, META=0x8000_0000.
  - Three DATA reads return A1, A2, A3; after the third, META=0 and STATUS=0.
- Full backpressure (DEPTH=4): stream 6 words inside one packet.
  - StReady_SO drops after word 4 and LEVEL=4, STATUS[1]=1.
  - One DATA read makes ready reassert the next cycle; all 6 words are read back in order.
- Framing errors:
  - A word without SOP while IDLE is dropped (LEVEL unchanged) and STATUS[2]=1.
  - SOP mid-packet sets STATUS[3]=1 and the word is stored.
  - CLRERR write clears both bits.
- Single-word packet (SOP=EOP=1, error=1): META=0x8000_0009 and PKTCNT=1. Popping it with a simultaneous new EOP arrival leaves PKTCNT=1.
- Flush mid-packet: after 2 words of an open packet, write CONTROL=1 with a word valid the same cycle.
  - LEVEL=0 and PKTCNT=0; the coincident word is discarded.
  - The next non-SOP word sets ORPHAN.
- Wait-state protocol: a read of any address shows WaitRequest 1 then 0 over exactly 2 cycles. A DATA read on an empty FIFO returns 0 and LEVEL stays 0.

Source files
------------

// File: rtl/avalon_st_rx_mailbox_if.sv
// ----------------------------------------------------------------------------
// avalon_st_rx_mailbox_if
//   Bundles the Avalon-ST sink signals and the Avalon-MM slave register
//   window of avalon_st_rx_mailbox.
//
//   Avalon-ST (source -> mailbox):
//     StValid_SI, StSop_SI, StEop_SI, StEmpty_SI[1:0], StError_SI, StData_DI
//     StReady_SO (mailbox -> source, readyLatency 0)
//   Avalon-MM (master -> mailbox):
//     MmAddress_DI, MmRead_SI, MmWrite_SI, MmWriteData_DI
//     MmReadData_DO, MmWaitRequest_SO (mailbox -> master)
//
//   Modports:
//     slave  - the mailbox side
//     master - the driving side (stream source plus MM master)
// ----------------------------------------------------------------------------
interface avalon_st_rx_mailbox_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int ERROR_WIDTH   = 1
);
    logic                     StReady_SO;
    logic                     StValid_SI;
    logic                     StSop_SI;
    logic                     StEop_SI;
    logic [1:0]               StEmpty_SI;
    logic [ERROR_WIDTH-1:0]   StError_SI;
    logic [DATA_WIDTH-1:0]    StData_DI;

    logic [ADDRESS_WIDTH-1:0] MmAddress_DI;
    logic                     MmRead_SI;
    logic                     MmWrite_SI;
    logic [DATA_WIDTH-1:0]    MmWriteData_DI;
    logic [DATA_WIDTH-1:0]    MmReadData_DO;
    logic                     MmWaitRequest_SO;

    modport slave (
        output StReady_SO,
        input  StValid_SI, StSop_SI, StEop_SI, StEmpty_SI, StError_SI, StData_DI,
        input  MmAddress_DI, MmRead_SI, MmWrite_SI, MmWriteData_DI,
        output MmReadData_DO, MmWaitRequest_SO
    );

    modport master (
        input  StReady_SO,
        output StValid_SI, StSop_SI, StEop_SI, StEmpty_SI, StError_SI, StData_DI,
        output MmAddress_DI, MmRead_SI, MmWrite_SI, MmWriteData_DI,
        input  MmReadData_DO, MmWaitRequest_SO
    );
endinterface

// File: rtl/avalon_st_rx_mailbox.sv
// ----------------------------------------------------------------------------
// avalon_st_rx_mailbox
//   Avalon-ST sink that stores incoming packet words in a FIFO and exposes
//   them to a processor through a small Avalon-MM register window.
//
//   Ports:
//     Clk_CI  - single rising-edge clock
//     Rst_RI  - synchronous active-high reset
//     Bus     - avalon_st_rx_mailbox_if.slave (ST sink + MM slave)
//
//   Register map (word addresses):
//     0x0 STATUS  [0] packets present, [1] full, [2] ORPHAN, [3] SOPERR,
//                 [31:16] packet count
//     0x1 DATA    head data word, pops on read (0 and no pop when empty)
//     0x2 META    [0] eop, [2:1] empty, [3] err, [31] non-empty (no pop)
//     0x3 LEVEL   words stored
//     0x4 CONTROL write-only: bit0 FLUSH, bit1 CLRERR
// ----------------------------------------------------------------------------
module avalon_st_rx_mailbox #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int ERROR_WIDTH   = 1,
    parameter int DEPTH         = 256
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    avalon_st_rx_mailbox_if.slave Bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WIDTH + 4;

    typedef enum logic {
        S_IDLE,
        S_IN_PKT
    } state_t;

    // FIFO entry layout: {data, eop, empty[1:0], err}
    logic [EW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [15:0]           r_pktcnt;
    logic                  r_orphan;
    logic                  r_soperr;
    logic                  r_ack;
    logic                  r_pop_pend;
    logic [DATA_WIDTH-1:0] r_rdata;
    state_t                r_state;

    logic                  w_full;
    logic                  w_nempty;
    logic                  w_ready;
    logic                  w_acc;
    logic                  w_in_pkt;
    logic                  w_push;
    logic                  w_push_eop;
    logic                  w_orphan_ev;
    logic                  w_soperr_ev;
    logic                  w_wr;
    logic                  w_ctrl_sel;
    logic                  w_flush;
    logic                  w_clrerr;
    logic                  w_rd_first;
    logic                  w_pop;
    logic                  w_pop_eop;
    logic [EW-1:0]         w_head;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_eop;
    logic [1:0]            w_head_empty;
    logic                  w_head_err;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic                  w_unused;

    // ------------------------------------------------------------------
    // Stream side
    // ------------------------------------------------------------------
    assign w_full   = (r_level == LW'(DEPTH));
    assign w_nempty = (r_level != '0);
    assign w_ready  = !Rst_RI && !w_full;
    assign w_acc    = Bus.StValid_SI && w_ready;
    assign w_in_pkt = (r_state == S_IN_PKT);

    // A word arriving with a FLUSH is dropped, so it never reaches the FIFO.
    assign w_push      = w_acc && (w_in_pkt || Bus.StSop_SI) && !w_flush;
    assign w_push_eop  = w_push && Bus.StEop_SI;
    assign w_orphan_ev = w_acc && !w_in_pkt && !Bus.StSop_SI;
    assign w_soperr_ev = w_acc && w_in_pkt && Bus.StSop_SI;

    assign Bus.StReady_SO = w_ready;

    // ------------------------------------------------------------------
    // MM side
    // ------------------------------------------------------------------
    assign w_wr       = Bus.MmWrite_SI && !Bus.MmRead_SI;
    assign w_ctrl_sel = w_wr && (Bus.MmAddress_DI == ADDRESS_WIDTH'(4));
    assign w_flush    = w_ctrl_sel && Bus.MmWriteData_DI[0];
    assign w_clrerr   = w_ctrl_sel && Bus.MmWriteData_DI[1];

    // First cycle of a read samples the register; the second acknowledges.
    assign w_rd_first = Bus.MmRead_SI && !r_ack;

    // The DATA pop is decided at sample time but lands on the ack cycle.
    assign w_pop     = Bus.MmRead_SI && r_ack && r_pop_pend && w_nempty;
    assign w_pop_eop = w_pop && w_head_eop;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_data  = w_head[EW-1:4];
    assign w_head_eop   = w_head[3];
    assign w_head_empty = w_head[2:1];
    assign w_head_err   = w_head[0];

    assign w_unused = ^Bus.MmWriteData_DI[DATA_WIDTH-1:2];

    always_comb begin
        w_rd_val = '0;
        case (Bus.MmAddress_DI)
            ADDRESS_WIDTH'(0): w_rd_val = {r_pktcnt, 12'b0, r_soperr, r_orphan,
                                           w_full, (r_pktcnt != '0)};
            ADDRESS_WIDTH'(1): w_rd_val = w_nempty ? w_head_data : '0;
            ADDRESS_WIDTH'(2): w_rd_val = w_nempty ? {1'b1, 27'b0, w_head_err,
                                                      w_head_empty, w_head_eop} : '0;
            ADDRESS_WIDTH'(3): w_rd_val = DATA_WIDTH'(r_level);
            default:           w_rd_val = '0;
        endcase
    end

    assign Bus.MmWaitRequest_SO = Rst_RI || w_rd_first;
    assign Bus.MmReadData_DO    = r_rdata;

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI || w_flush) begin
            r_state <= S_IDLE;
        end else if (w_push) begin
            r_state <= Bus.StEop_SI ? S_IDLE : S_IN_PKT;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_CI) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {Bus.StData_DI, Bus.StEop_SI, Bus.StEmpty_SI,
                                |Bus.StError_SI};
        end
    end

    // ------------------------------------------------------------------
    // Pointers, counters, sticky flags and MM read path
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_pktcnt   <= '0;
            r_orphan   <= 1'b0;
            r_soperr   <= 1'b0;
            r_ack      <= 1'b0;
            r_pop_pend <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack <= w_rd_first;
            if (w_rd_first) begin
                r_rdata    <= w_rd_val;
                r_pop_pend <= (Bus.MmAddress_DI == ADDRESS_WIDTH'(1)) && w_nempty;
            end

            // A new event wins over a coincident clear.
            r_orphan <= (r_orphan && !w_clrerr) || w_orphan_ev;
            r_soperr <= (r_soperr && !w_clrerr) || w_soperr_ev;

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_pktcnt <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase

                case ({w_push_eop, w_pop_eop})
                    2'b10:   r_pktcnt <= r_pktcnt + 1'b1;
                    2'b01:   r_pktcnt <= r_pktcnt - 1'b1;
                    default: r_pktcnt <= r_pktcnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avalon_st_rx_mailbox.sv
module tb_avalon_st_rx_mailbox;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avalon_st_rx_mailbox_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .ERROR_WIDTH(1)) bus ();

    avalon_st_rx_mailbox #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(8), .ERROR_WIDTH(1), .DEPTH(DEPTH)
    ) dut (
        .Clk_CI(clk),
        .Rst_RI(rst),
        .Bus(bus)
    );

    // Reference model: a queue of stored words plus framing/sticky state.
    typedef struct {
        logic [31:0] d;
        bit          eop;
        bit [1:0]    emp;
        bit          err;
    } ent_t;

    ent_t q[$];
    bit   m_inpkt;
    bit   m_orphan;
    bit   m_soperr;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pkts();
        int n = 0;
        foreach (q[i]) if (q[i].eop) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_reg(input logic [7:0] a);
        int          lvl = q.size();
        logic [15:0] pk  = 16'(pkts());
        case (a)
            8'd0:    return {pk, 12'b0, m_soperr, m_orphan, (lvl == DEPTH), (pk != 0)};
            8'd1:    return (lvl > 0) ? q[0].d : 32'h0;
            8'd2:    return (lvl > 0) ? {1'b1, 27'b0, q[0].err, q[0].emp, q[0].eop} : 32'h0;
            8'd3:    return 32'(lvl);
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle with whatever inputs are currently driven.
    task automatic tick(input bit do_pop);
        bit   rdy, acc, wr, ctl, flush, clr, keep, ev_o, ev_s;
        ent_t e;
        #1;
        rdy = !rst && (q.size() < DEPTH);
        chk("st_ready", {31'b0, bus.StReady_SO}, {31'b0, rdy});
        acc   = bus.StValid_SI && rdy;
        wr    = bus.MmWrite_SI && !bus.MmRead_SI;
        ctl   = wr && (bus.MmAddress_DI == 8'd4);
        flush = ctl && bus.MmWriteData_DI[0];
        clr   = ctl && bus.MmWriteData_DI[1];
        ev_o  = acc && !m_inpkt && !bus.StSop_SI;
        ev_s  = acc && m_inpkt && bus.StSop_SI;
        keep  = acc && (m_inpkt || bus.StSop_SI);
        e.d   = bus.StData_DI;
        e.eop = bus.StEop_SI;
        e.emp = bus.StEmpty_SI;
        e.err = |bus.StError_SI;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_inpkt  = 0;
            m_orphan = 0;
            m_soperr = 0;
        end else begin
            if (do_pop && q.size() > 0) void'(q.pop_front());
            if (keep && !flush) begin
                q.push_back(e);
                m_inpkt = !e.eop;
            end
            if (flush) begin
                q.delete();
                m_inpkt = 0;
            end
            m_orphan = (m_orphan && !clr) || ev_o;
            m_soperr = (m_soperr && !clr) || ev_s;
        end
        #1;
    endtask

    // Two-cycle MM read; 'arm' raises StValid_SI during the acknowledge cycle.
    task automatic rd(input logic [7:0] a, output logic [31:0] d, input bit arm = 0);
        logic [31:0] exp;
        bit          popme;
        bus.MmAddress_DI = a;
        bus.MmRead_SI    = 1'b1;
        #1;
        chk("wait_first", {31'b0, bus.MmWaitRequest_SO}, 32'd1);
        exp   = model_reg(a);
        popme = (a == 8'd1) && (q.size() > 0);
        tick(0);
        chk("wait_ack", {31'b0, bus.MmWaitRequest_SO}, 32'd0);
        chk($sformatf("rd_%0h", a), bus.MmReadData_DO, exp);
        d = bus.MmReadData_DO;
        if (arm) bus.StValid_SI = 1'b1;
        tick(popme);
        bus.StValid_SI = 1'b0;
        bus.MmRead_SI  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] v);
        bus.MmAddress_DI   = a;
        bus.MmWriteData_DI = v;
        bus.MmWrite_SI     = 1'b1;
        #1;
        chk("wait_write", {31'b0, bus.MmWaitRequest_SO}, 32'd0);
        tick(0);
        bus.MmWrite_SI = 1'b0;
    endtask

    task automatic set_st(input bit sop, input bit eop, input bit [1:0] emp,
                          input bit err, input logic [31:0] d);
        bus.StSop_SI   = sop;
        bus.StEop_SI   = eop;
        bus.StEmpty_SI = emp;
        bus.StError_SI = err;
        bus.StData_DI  = d;
    endtask

    task automatic send(input bit sop, input bit eop, input bit [1:0] emp,
                        input bit err, input logic [31:0] d);
        set_st(sop, eop, emp, err, d);
        bus.StValid_SI = 1'b1;
        tick(0);
        bus.StValid_SI = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          r;

        bus.StValid_SI = 0; set_st(0, 0, 0, 0, 0);
        bus.MmAddress_DI = 0; bus.MmRead_SI = 0; bus.MmWrite_SI = 0; bus.MmWriteData_DI = 0;
        m_inpkt = 0; m_orphan = 0; m_soperr = 0;

        // Reset state
        rst = 1;
        tick(0);
        tick(0);
        chk("rst_wait", {31'b0, bus.MmWaitRequest_SO}, 32'd1);
        chk("rst_rdata", bus.MmReadData_DO, 32'd0);
        chk("rst_ready", {31'b0, bus.StReady_SO}, 32'd0);
        rst = 0;
        tick(0);

        // Three-word packet
        send(1, 0, 0, 0, 32'hA1);
        send(0, 0, 0, 0, 32'hA2);
        send(0, 1, 2, 0, 32'hA3);
        rd(0, d); chk("pkt_status", d, 32'h0001_0001);
        rd(3, d); chk("pkt_level", d, 32'd3);
        rd(2, d); chk("pkt_meta", d, 32'h8000_0000);
        rd(1, d); chk("pkt_d0", d, 32'hA1);
        rd(1, d); chk("pkt_d1", d, 32'hA2);
        rd(1, d); chk("pkt_d2", d, 32'hA3);
        rd(2, d); chk("pkt_meta_empty", d, 32'h0);
        rd(0, d); chk("pkt_status_empty", d, 32'h0);

        // Full backpressure
        send(1, 0, 0, 0, 32'hB0);
        send(0, 0, 0, 0, 32'hB1);
        send(0, 0, 0, 0, 32'hB2);
        send(0, 0, 0, 0, 32'hB3);
        chk("full_ready", {31'b0, bus.StReady_SO}, 32'd0);
        rd(3, d); chk("full_level", d, 32'd4);
        rd(0, d); chk("full_bit", {31'b0, d[1]}, 32'd1);
        set_st(0, 0, 0, 0, 32'hB4);
        bus.StValid_SI = 1'b1;
        rd(1, d); chk("full_d0", d, 32'hB0);
        bus.StValid_SI = 1'b1;
        chk("ready_after_pop", {31'b0, bus.StReady_SO}, 32'd1);
        tick(0);
        bus.StValid_SI = 1'b0;
        rd(1, d); chk("full_d1", d, 32'hB1);
        send(0, 1, 1, 0, 32'hB5);
        for (int unsigned i = 2; i < 6; i++) begin
            rd(1, d); chk("full_dn", d, 32'hB0 + i);
        end

        // Framing errors
        send(0, 0, 0, 0, 32'hC0);
        rd(3, d); chk("orphan_level", d, 32'd0);
        rd(0, d); chk("orphan_bit", {31'b0, d[2]}, 32'd1);
        send(1, 0, 0, 0, 32'hC1);
        send(1, 0, 0, 0, 32'hC2);
        send(0, 1, 0, 0, 32'hC3);
        rd(0, d); chk("soperr_bit", {31'b0, d[3]}, 32'd1);
        rd(3, d); chk("soperr_level", d, 32'd3);
        wr(4, 32'h2);
        rd(0, d); chk("clrerr", {30'b0, d[3:2]}, 32'd0);
        repeat (3) rd(1, d);

        // Single-word packet, pop coincident with a new EOP arrival
        send(1, 1, 0, 1, 32'hD0);
        rd(2, d); chk("single_meta", d, 32'h8000_0009);
        rd(0, d); chk("single_pkt", {16'b0, d[31:16]}, 32'd1);
        set_st(1, 1, 3, 0, 32'hD1);
        rd(1, d, 1); chk("single_d", d, 32'hD0);
        rd(0, d); chk("pop_push_pkt", {16'b0, d[31:16]}, 32'd1);
        rd(1, d);

        // Flush mid-packet with a coincident word
        send(1, 0, 0, 0, 32'hE0);
        send(0, 0, 0, 0, 32'hE1);
        set_st(0, 0, 0, 0, 32'hE2);
        bus.StValid_SI = 1'b1;
        wr(4, 32'h1);
        bus.StValid_SI = 1'b0;
        rd(3, d); chk("flush_level", d, 32'd0);
        rd(0, d); chk("flush_status", d, 32'd0);
        send(0, 0, 0, 0, 32'hE3);
        rd(0, d); chk("flush_orphan", {31'b0, d[2]}, 32'd1);
        wr(4, 32'h2);

        // Reset with a packet in flight
        send(1, 0, 0, 0, 32'hF0);
        rst = 1;
        tick(0);
        rst = 0;
        send(0, 1, 0, 0, 32'hF1);
        rd(3, d); chk("rst_inflight_level", d, 32'd0);
        rd(0, d); chk("rst_inflight_orphan", {31'b0, d[2]}, 32'd1);
        wr(4, 32'h2);

        // Wait-state protocol, empty reads, read-data hold
        rd(8'h20, d); chk("unmapped", d, 32'd0);
        rd(4, d); chk("control_reads0", d, 32'd0);
        rd(1, d); chk("empty_data", d, 32'd0);
        rd(3, d); chk("empty_level", d, 32'd0);
        send(1, 0, 0, 0, 32'h55);
        rd(3, d);
        tick(0);
        tick(0);
        chk("rdata_hold", bus.MmReadData_DO, 32'd1);
        wr(4, 32'h3);

        // Randomized traffic against the model
        for (int unsigned it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                send($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                     2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom());
            end else if (r < 85) begin
                rd(($urandom_range(0, 1) == 0) ? 8'd1 : 8'($urandom_range(0, 5)), d);
            end else if (r < 92) begin
                wr(4, 32'h2);
            end else if (r < 95) begin
                wr(4, 32'h1);
            end else begin
                wr(($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3))
                                               : 8'($urandom_range(5, 255)), $urandom());
            end
        end
        while (q.size() > 0) rd(1, d);
        rd(0, d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
